// File: rtl/reg_pipe_line.sv
// Parametrised register delay line with per-stage valid bits, advance enable and flush.
// Optional output register stage enabled by defining REG_PIPE_OUT_REG_EN.
module reg_pipe_line #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic                         flush,
    input  logic                         in_valid,
    input  logic [WIDTH-1:0]             in_data,
    output logic                         out_valid,
    output logic [WIDTH-1:0]             out_data,
    output logic [WIDTH-1:0]             tap_data,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

    localparam int OCC_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] data_q [DEPTH];
    logic [DEPTH-1:0] vld_q;
    logic [OCC_W-1:0] occ_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
            end
            vld_q <= '0;
            occ_q <= '0;
        end else if (flush) begin
            // data is kept so a flushed pipe still shows its last word on out_data
            vld_q <= '0;
            occ_q <= '0;
        end else if (en) begin
            data_q[0] <= in_data;
            vld_q[0]  <= in_valid;
            for (int i = 1; i < DEPTH; i++) begin
                data_q[i] <= data_q[i-1];
                vld_q[i]  <= vld_q[i-1];
            end
            occ_q <= occ_q + OCC_W'(in_valid) - OCC_W'(vld_q[DEPTH-1]);
        end
    end

    assign tap_data  = data_q[0];
    assign occupancy = occ_q;

`ifdef REG_PIPE_OUT_REG_EN
    // output register reloads every edge, independent of en
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data  <= '0;
            out_valid <= 1'b0;
        end else begin
            out_data  <= data_q[DEPTH-1];
            out_valid <= flush ? 1'b0 : vld_q[DEPTH-1];
        end
    end
`else
    assign out_data  = data_q[DEPTH-1];
    assign out_valid = vld_q[DEPTH-1];
`endif

endmodule

// File: tb/tb_reg_pipe_line.sv
// Directed self-checking bench for reg_pipe_line (WIDTH=8, DEPTH=4).
// Expectations adapt to REG_PIPE_OUT_REG_EN via the output latency constant.
module tb_reg_pipe_line;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
`ifdef REG_PIPE_OUT_REG_EN
    localparam int LAT = DEPTH + 1;
`else
    localparam int LAT = DEPTH;
`endif

    logic             clk;
    logic             rst;
    logic             en;
    logic             flush;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic [WIDTH-1:0] tap_data;
    logic [2:0]       occupancy;

    int checks = 0;
    int errors = 0;

    reg_pipe_line #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_data  (out_data),
        .tap_data  (tap_data),
        .occupancy (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; flush = 1'b1; in_valid = 1'b1; in_data = 8'hFF;
        step();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++;
        if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data got=%h exp=00", out_data); end
        checks++;
        if (tap_data !== 8'h00) begin errors++; $display("FAIL reset_tap got=%h exp=00", tap_data); end
        checks++;
        if (occupancy !== 3'd0) begin errors++; $display("FAIL reset_occ got=%0d exp=0", occupancy); end
        rst = 1'b0; flush = 1'b0; en = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    endtask

    task automatic test_stream();
        int idx, lo, hi, occ_exp;
        logic [7:0] exp_d;
        logic       exp_v;
        en = 1'b1;
        for (int k = 0; k < 10; k++) begin
            if (k < 5) begin
                in_valid = 1'b1;
                in_data  = 8'(8'h11 * (k + 1));
            end else begin
                in_valid = 1'b0;
                in_data  = 8'h00;
            end
            step();
            idx = k - LAT + 1;
            exp_v = (idx >= 0 && idx < 5);
            exp_d = exp_v ? 8'(8'h11 * (idx + 1)) : 8'h00;
            lo = (k - 3 > 0) ? k - 3 : 0;
            hi = (k < 4) ? k : 4;
            occ_exp = (hi >= lo) ? hi - lo + 1 : 0;
            checks++;
            if (out_valid !== exp_v) begin errors++; $display("FAIL stream_valid k=%0d got=%b exp=%b", k, out_valid, exp_v); end
            checks++;
            if (out_data !== exp_d) begin errors++; $display("FAIL stream_data k=%0d got=%h exp=%h", k, out_data, exp_d); end
            checks++;
            if (occupancy !== 3'(occ_exp)) begin errors++; $display("FAIL stream_occ k=%0d got=%0d exp=%0d", k, occupancy, occ_exp); end
        end
    endtask

    task automatic test_tap();
        en = 1'b1; in_valid = 1'b1; in_data = 8'hA5;
        step();
        checks++;
        if (tap_data !== 8'hA5) begin errors++; $display("FAIL tap_load got=%h exp=a5", tap_data); end
        en = 1'b0; in_data = 8'h5A;
        step();
        checks++;
        if (tap_data !== 8'hA5) begin errors++; $display("FAIL tap_hold got=%h exp=a5", tap_data); end
        in_data = 8'h3C;
        step();
        checks++;
        if (tap_data !== 8'hA5) begin errors++; $display("FAIL tap_hold2 got=%h exp=a5", tap_data); end
    endtask

    task automatic test_stall();
        flush = 1'b1; en = 1'b0; in_valid = 1'b0;
        step();
        flush = 1'b0;
        checks++;
        if (occupancy !== 3'd0) begin errors++; $display("FAIL stall_flush_occ got=%0d exp=0", occupancy); end
        en = 1'b1; in_valid = 1'b1; in_data = 8'h01;
        step();
        en = 1'b0; in_valid = 1'b0; in_data = 8'hEE;
        for (int s = 0; s < 3; s++) begin
            step();
            checks++;
            if (occupancy !== 3'd1) begin errors++; $display("FAIL stall_occ s=%0d got=%0d exp=1", s, occupancy); end
            checks++;
            if (out_valid !== 1'b0) begin errors++; $display("FAIL stall_valid s=%0d got=%b exp=0", s, out_valid); end
        end
        en = 1'b1;
        for (int s = 1; s <= LAT - 1; s++) begin
            step();
            checks++;
            if (out_valid !== (s == LAT - 1)) begin
                errors++; $display("FAIL stall_emerge_valid s=%0d got=%b exp=%b", s, out_valid, (s == LAT - 1));
            end
        end
        checks++;
        if (out_data !== 8'h01) begin errors++; $display("FAIL stall_emerge_data got=%h exp=01", out_data); end
    endtask

    task automatic test_flush();
        en = 1'b1; in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in_data = 8'(8'hB1 + k);
            step();
        end
        checks++;
        if (occupancy !== 3'd4) begin errors++; $display("FAIL flush_full_occ got=%0d exp=4", occupancy); end
        flush = 1'b1; in_data = 8'h66;
        step();
        flush = 1'b0;
        checks++;
        if (occupancy !== 3'd0) begin errors++; $display("FAIL flush_occ got=%0d exp=0", occupancy); end
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got=%b exp=0", out_valid); end
        checks++;
        if (out_data !== 8'hB1) begin errors++; $display("FAIL flush_data got=%h exp=b1", out_data); end
        checks++;
        if (tap_data !== 8'hB4) begin errors++; $display("FAIL flush_tap got=%h exp=b4", tap_data); end
        in_valid = 1'b0; in_data = 8'h00;
        for (int k = 0; k < 6; k++) begin
            step();
            checks++;
            if (out_valid !== 1'b0 || out_data === 8'h66) begin
                errors++; $display("FAIL flush_drain k=%0d got=%b/%h exp=0/not66", k, out_valid, out_data);
            end
        end
    endtask

    task automatic test_alternating();
        int idx, lo, occ_exp;
        logic exp_v;
        en = 1'b1;
        for (int k = 0; k < 10; k++) begin
            in_valid = (k % 2 == 0);
            in_data  = 8'(8'h70 + k);
            step();
            idx = k - LAT + 1;
            exp_v = (idx >= 0) && (idx % 2 == 0);
            lo = (k - 3 > 0) ? k - 3 : 0;
            occ_exp = 0;
            for (int j = lo; j <= k; j++) if (j % 2 == 0) occ_exp++;
            checks++;
            if (out_valid !== exp_v) begin errors++; $display("FAIL alt_valid k=%0d got=%b exp=%b", k, out_valid, exp_v); end
            checks++;
            if (occupancy !== 3'(occ_exp)) begin errors++; $display("FAIL alt_occ k=%0d got=%0d exp=%0d", k, occupancy, occ_exp); end
            if (exp_v) begin
                checks++;
                if (out_data !== 8'(8'h70 + idx)) begin errors++; $display("FAIL alt_data k=%0d got=%h exp=%h", k, out_data, 8'(8'h70 + idx)); end
            end
        end
        rst = 1'b1; in_valid = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || tap_data !== 8'h00 || occupancy !== 3'd0) begin
            errors++;
            $display("FAIL midrst got=%b/%h/%h/%0d exp=0/00/00/0", out_valid, out_data, tap_data, occupancy);
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        test_reset();
        test_stream();
        test_tap();
        test_stall();
        test_flush();
        test_alternating();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
